// File: rtl/serial_pkg.sv
// Shared types for the serial frame transmitter: bit-level states, frame
// sequencing states, parity-mode constants and the parity helper.
package serial_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // F_ARMED is the cycle between accepting send and the first GAP check
    typedef enum logic [1:0] {
        F_IDLE,
        F_ARMED,
        F_GAP,
        F_BYTE
    } frame_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/serial_tx_byte.sv
// Serialises one byte: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, each lasting CLK_PER_BIT clocks.
module serial_tx_byte
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 50,
    parameter int PARITY      = PAR_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLK_PER_BIT - 1);

    state_t          state;
    state_t          state_nx;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic            stop_cnt;
    logic [7:0]      shift;
    logic            par;
    logic            wrap;
    logic            last_stop;

    assign wrap      = (timer == TMAX);
    assign last_stop = (STOP_BITS == 2) ? stop_cnt : 1'b1;

    always_comb begin
        state_nx  = state;
        byte_done = 1'b0;
        case (state)
            S_IDLE:   if (load) state_nx = S_START;
            S_START:  if (wrap) state_nx = S_DATA;
            S_DATA: begin
                if (wrap && (bit_cnt == 3'd7))
                    state_nx = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (wrap) state_nx = S_STOP;
            S_STOP: begin
                if (wrap && last_stop) begin
                    state_nx  = S_IDLE;
                    byte_done = 1'b1;
                end
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Timer only runs while a byte is on the line so every bit starts at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            par      <= 1'b0;
        end else if (state == S_IDLE) begin
            timer <= '0;
            if (load) begin
                shift    <= byte_in;
                par      <= parity_bit(byte_in, PARITY);
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
            end
        end else begin
            timer <= wrap ? '0 : timer + 1'b1;
            if (wrap) begin
                if (state == S_DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == S_STOP)
                    stop_cnt <= ~stop_cnt;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift[0];
            S_PARITY: tx = par;
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/serial_tx_frame.sv
// UART-style message transmitter: latches MSG_LEN bytes on send and sends them
// with block flow control at byte boundaries. SERIAL_TX_FRAME_CHKSUM_EN appends an XOR checksum byte.
module serial_tx_frame
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 50,
    parameter int MSG_LEN     = 4,
    parameter int PARITY      = PAR_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 block,
    input  logic                 send,
    input  logic [8*MSG_LEN-1:0] msg,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = $clog2(MSG_LEN + 1);
`ifdef SERIAL_TX_FRAME_CHKSUM_EN
    localparam int NBYTES = MSG_LEN + 1;
`else
    localparam int NBYTES = MSG_LEN;
`endif
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    frame_t               fstate;
    frame_t               fstate_nx;
    logic [8*MSG_LEN-1:0] msg_q;
    logic [IW-1:0]        idx;
    logic                 done_q;
    logic                 load;
    logic                 byte_done;
    logic [7:0]           cur_byte;
    logic                 accept;
    logic                 last_byte;

    // The done cycle is already IDLE, but a send there must not be taken
    assign accept    = (fstate == F_IDLE) && send && !done_q;
    assign last_byte = (idx == LAST_IDX);

    always_comb begin
        fstate_nx = fstate;
        load      = 1'b0;
        case (fstate)
            F_IDLE:  if (accept) fstate_nx = F_ARMED;
            F_ARMED: fstate_nx = F_GAP;
            F_GAP: begin
                if (!block) begin
                    load      = 1'b1;
                    fstate_nx = F_BYTE;
                end
            end
            F_BYTE:  if (byte_done) fstate_nx = last_byte ? F_IDLE : F_GAP;
            default: fstate_nx = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fstate <= F_IDLE;
        else      fstate <= fstate_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_q  <= '0;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (fstate == F_BYTE) && byte_done && last_byte;
            if (accept) begin
                msg_q <= msg;
                idx   <= '0;
            end else if ((fstate == F_BYTE) && byte_done && !last_byte) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef SERIAL_TX_FRAME_CHKSUM_EN
    logic [7:0] chksum;

    always_comb begin
        chksum = '0;
        for (int i = 0; i < MSG_LEN; i++)
            chksum = chksum ^ msg_q[8*i +: 8];
    end
`endif

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < MSG_LEN; i++)
            if (idx == IW'(i)) cur_byte = msg_q[8*i +: 8];
`ifdef SERIAL_TX_FRAME_CHKSUM_EN
        if (idx == IW'(MSG_LEN)) cur_byte = chksum;
`endif
    end

    // ARMED is excluded so busy rises together with the first GAP
    assign busy = (fstate == F_GAP) || (fstate == F_BYTE);
    assign done = done_q;

    serial_tx_byte #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .PARITY      (PARITY),
        .STOP_BITS   (STOP_BITS)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .byte_in   (cur_byte),
        .tx        (tx),
        .byte_done (byte_done)
    );

endmodule

// File: doc/serial_tx_frame.md
# serial_tx_frame

Parametrised UART-style frame transmitter: on a one-cycle `send` strobe it latches an `MSG_LEN`-byte message and serialises it byte by byte (start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits) on `tx`.
- Honours an upstream `block` flow-control input at byte boundaries.
- Reports `busy` and a `done` pulse.
- Sits between the message-producing logic and the board's serial pin, for example the AVR link on the Mojo.

## Interface

Parameters:
- `CLK_PER_BIT`, 50: clock cycles per bit period (≥2).
- `MSG_LEN`, 4: message length in bytes (≥1).
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `block`  in  1  high = receiver not ready; no new byte may start.
- `send`  in  1  one-cycle request to transmit `msg`.
- `msg`  in  8*MSG_LEN  message; byte 0 = `msg[7:0]`, sent first.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress; `send` is ignored while high.
- `done`  out  1  one-cycle pulse after the last stop bit of the frame.

## Operation

- Reset (`rst`=0) values: `tx`=1, `busy`=0, `done`=0, state IDLE, counters 0, shift register 0.
  - Reset mid-frame aborts immediately: `tx` goes high asynchronously and no `done` is issued.
- States:
  - IDLE: `send`=1 latches `msg`, byte index 0 → GAP. `send` is ignored in every other state.
  - GAP: byte-boundary check. `block`=0 → START, loading the current byte. `block`=1 → stay, `tx`=1.
  - START: `tx`=0 for one bit period → DATA.
  - DATA: 8 bits, LSB first → PARITY if `PARITY`≠0, else STOP.
  - PARITY: odd → bit makes the total count of ones in data+parity odd; even → even.
  - STOP: `tx`=1 for `STOP_BITS` periods. Then:
    - more bytes remain (or the checksum byte is pending) → GAP with index+1;
    - otherwise → IDLE with a `done` pulse.
- `block` is sampled only in GAP. Asserting it mid-byte never truncates that byte.
- Bit timer counts 0..CLK_PER_BIT-1; a wrap advances the bit. Timer width is `$clog2(CLK_PER_BIT)`; byte-index width is `$clog2(MSG_LEN+1)`.
- `busy`=1 in every state except IDLE.

## Timing

- `send` sampled high at edge k with `block`=0:
  - `busy` rises after edge k+1;
  - start bit on `tx` from edge k+2.
- Bits per byte: B = 10 + (PARITY≠0) + (STOP_BITS−1). Each byte takes B·CLK_PER_BIT cycles plus one GAP cycle.
- Unblocked frame: start-bit edge to `done` edge = N·(B·CLK_PER_BIT+1) − 1 cycles, where N = MSG_LEN (+1 with checksum).
- `done` is high for exactly the cycle in which state returns to IDLE. A `send` in that same cycle is ignored; the next accepted `send` is one cycle later.
- `msg` may change freely after the accepting edge.

## Configuration

- `SERIAL_TX_FRAME_CHKSUM_EN` defined:
  - after byte MSG_LEN−1, one extra byte is sent, equal to the XOR of all message bytes;
  - it is framed identically and is also subject to `block`.
- `SERIAL_TX_FRAME_CHKSUM_EN` undefined: exactly MSG_LEN bytes per frame, and no checksum logic is present.

## Structure

- Package `serial_pkg`:
  - state enum (IDLE, GAP, START, DATA, PARITY, STOP);
  - parity-mode constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
- Sub-module `serial_tx_byte`: bit timer, start/data/parity/stop sequencing, `tx` drive.
  - Handshake: `load`/`byte_in` in, `byte_done` out.
- Top level: message latch, byte indexing, `block` gating, checksum, `busy`/`done`.

## Test plan

Bench settings: CLK_PER_BIT=4, MSG_LEN=4, `msg`=32'h81F0CCAA.
- Basic frame (PARITY=0, STOP_BITS=1, `block`=0), pulse `send` → `tx` shows bytes AA, CC, F0, 81 LSB-first with correct start/stop bits. `done` comes 163 cycles after start-bit onset; `busy` falls with it.
- Parity (PARITY=2, then PARITY=1) → parity bit after 0xAA is 0 (even) and 1 (odd); after 0x81 it is 0 and 1 respectively.
- Flow control: hold `block`=1, pulse `send` → `tx` stays 1 and `busy`=1. Release `block` → first start bit 1 cycle later.
  - Re-assert `block` mid-byte 2 → byte 2 completes, then `tx` holds high until release.
- Busy/collision: pulse `send` again mid-frame with different `msg` → ignored; the original four bytes are sent and there is one `done`.
- Reset mid-frame: drop `rst` during DATA of byte 1 → `tx`=1 and `busy`=0 immediately, no `done`. A `send` after release restarts from byte 0.
- With `SERIAL_TX_FRAME_CHKSUM_EN` → fifth byte is 0x17; `done` comes 204 cycles after start-bit onset.
